pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 9'd0, SHALL be the start address loaded on every start.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries (legal range 1..8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous active-low reset.
REQ-005 start  input  1  SHALL request a program start in IDLE or HALT.
REQ-006 stall  input  1  SHALL freeze sequencing for the current cycle.
REQ-007 halt_req  input  1  SHALL request halt in RUN.
REQ-008 br_taken  input  1  SHALL request a branch to br_target this cycle.
REQ-009 br_rel  input  1  SHALL select addressing: 1 = pc + signed br_target, 0 = absolute br_target.
REQ-010 br_target  input  9  SHALL be the absolute address or two's-complement offset.
REQ-011 call  input  1  SHALL request a jump, addressed like a branch, that pushes the return address.
REQ-012 ret  input  1  SHALL request a jump to the popped return address.
REQ-013 pc  input  9  SHALL be the current value of the program_counter result output.
REQ-014 pc_next  output  9  SHALL drive the program_counter next input.
REQ-015 pc_write  output  1  SHALL drive the program_counter write input.
REQ-016 running  output  1  SHALL be high exactly when state = RUN.
REQ-017 done  output  1  SHALL be high exactly when state = HALT.
REQ-018 stack_err  output  1  SHALL be a sticky return-stack overflow/underflow flag.

Function
REQ-019 The FSM SHALL have the states IDLE, RUN and HALT, registered; pc_next and pc_write SHALL be combinational from state and inputs.
REQ-020 IDLE/HALT with start=1 SHALL drive pc_write=1 and pc_next=RESET_VEC, clear the stack pointer, and enter RUN on the next edge; otherwise pc_write=0.
REQ-021 HALT SHALL NOT clear stack_err on start; only reset clears it.
REQ-022 In RUN, the per-cycle priority SHALL be: stall > halt_req > ret > call > br_taken > sequential.
REQ-023 In RUN with stall=1: pc_write=0; no change to state, stack or stack_err.
REQ-024 In RUN with halt_req=1 (stall=0): pc_write=0; next state HALT; all other requests ignored.
REQ-025 A sequential cycle SHALL drive pc_next=pc+1 modulo 512 (511 -> 0) with pc_write=1.
REQ-026 br_taken SHALL drive pc_next=target with pc_write=1. Target: br_rel=0 gives br_target; br_rel=1 gives (pc + sign-extended br_target) mod 512.
REQ-027 call SHALL push (pc+1) mod 512, drive pc_next=target (as in REQ-026) with pc_write=1, and ignore br_taken.
REQ-028 ret SHALL pop the top entry, drive it on pc_next with pc_write=1, and ignore call and br_taken.
REQ-029 call when the stack holds STACK_DEPTH entries SHALL set stack_err, suppress the push, and still take the jump.
REQ-030 ret when the stack is empty SHALL set stack_err, leave the stack unchanged, and behave as sequential (pc+1).
REQ-031 The new PC SHALL be visible on pc one cycle after the edge that sampled pc_write=1 (latency 1).
REQ-032 running and done SHALL be registered decodes of state with no extra latency.

Reset
REQ-033 reset=0 SHALL asynchronously force state=IDLE, stack pointer=0, and stack_err=0; running, done and pc_write SHALL read 0 while reset is low.
REQ-034 Return-stack entry contents need not be reset.
REQ-035 Reset asserted mid-RUN SHALL abort with no further pc_write; after release, operation resumes only on start.

Verification
REQ-036 Reset, then start=1 for one cycle with RESET_VEC=0 -> pc_write=1 with pc_next=0; running=1 next cycle; pc then counts 0,1,2,3 on successive cycles.
REQ-037 pc=510, sequential for 3 cycles -> pc sequence 510,511,0,1; no error.
REQ-038 pc=20, br_taken=1, br_rel=1, br_target=9'h1FC (-4) -> pc=16 next cycle; at pc=20 with br_rel=0, br_target=42 -> pc=42.
REQ-039 pc=10, call with absolute target 100 -> pc=100; later ret -> pc=11. Five nested calls with STACK_DEPTH=4 -> stack_err=1 on the fifth, and that jump is still taken.
REQ-040 RUN, pc=7: stall+halt_req together -> no change. halt_req alone -> pc_write=0, done=1, pc stays 7. start -> pc=RESET_VEC and running=1.
REQ-041 ret with an empty stack at pc=30 -> pc=31 and stack_err=1. stack_err persists through halt and start, and clears only on reset=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/HALT program-counter sequencer with branch, call/return stack and sticky stack error.
// Parameters:
//   RESET_VEC    start address loaded on every start
//   STACK_DEPTH  return-stack entries (1..8)
// Inputs:
//   clk_i, rst_ni (async active-low)
//   start_i, stall_i, halt_req_i
//   br_taken_i, br_rel_i, br_target_i[8:0]
//   call_i, ret_i
//   pc_i[8:0] (current PC register value)
// Outputs:
//   pc_next_o[8:0], pc_write_o (drive the external PC register)
//   running_o, done_o, stack_err_o
module pc_sequencer #(
  parameter logic [8:0] RESET_VEC   = 9'd0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stall_i,
  input  logic       halt_req_i,
  input  logic       br_taken_i,
  input  logic       br_rel_i,
  input  logic [8:0] br_target_i,
  input  logic       call_i,
  input  logic       ret_i,
  input  logic [8:0] pc_i,
  output logic [8:0] pc_next_o,
  output logic       pc_write_o,
  output logic       running_o,
  output logic       done_o,
  output logic       stack_err_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  state_t         state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push, wr;
  logic [8:0]     stk_q [STACK_DEPTH];
  logic [8:0]     pc_inc, tgt;
  // A 9-bit add wraps mod 512, so a signed offset needs no explicit sign extension.
  assign pc_inc = pc_i + 9'd1;
  assign tgt    = br_rel_i ? pc_i + br_target_i : br_target_i;
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    err_d     = err_q;
    push      = 1'b0;
    wr        = 1'b0;
    pc_next_o = pc_inc;
    if (state_q == RUN) begin
      if (!stall_i) begin
        if (halt_req_i) state_d = HALT;
        else begin
          wr = 1'b1;
          if (ret_i) begin
            if (sp_q == '0) err_d = 1'b1;
            else begin
              pc_next_o = stk_q[IW'(sp_q - 1'b1)];
              sp_d      = sp_q - 1'b1;
            end
          end else if (call_i) begin
            pc_next_o = tgt;
            if (sp_q == SPW'(STACK_DEPTH)) err_d = 1'b1;
            else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
            end
          end else if (br_taken_i) pc_next_o = tgt;
        end
      end
    end else if (start_i) begin
      wr        = 1'b1;
      pc_next_o = RESET_VEC;
      sp_d      = '0;
      state_d   = RUN;
    end
  end
  // Gate the write so an IDLE+start combination cannot leak through while reset is held.
  assign pc_write_o  = wr & rst_ni;
  assign running_o   = state_q == RUN;
  assign done_o      = state_q == HALT;
  assign stack_err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) stk_q[IW'(sp_q)] <= pc_inc;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer with a modelled external PC register.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic       br_taken = 1'b0, br_rel = 1'b0, call = 1'b0, ret = 1'b0;
  logic [8:0] br_target = '0;
  logic [8:0] pc = 9'h1AA;
  logic [8:0] pc_next;
  logic       pc_write, running, done, stack_err;
  int         n_chk = 0;
  int         n_fail = 0;
  pc_sequencer #(.RESET_VEC(9'd0), .STACK_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stall_i(stall), .halt_req_i(halt_req),
    .br_taken_i(br_taken), .br_rel_i(br_rel), .br_target_i(br_target),
    .call_i(call), .ret_i(ret), .pc_i(pc),
    .pc_next_o(pc_next), .pc_write_o(pc_write), .running_o(running),
    .done_o(done), .stack_err_o(stack_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (pc_write) pc <= pc_next;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    {start, stall, halt_req, br_taken, br_rel, call, ret} = '0;
    br_target = '0;
  endtask
  task automatic go_abs(input logic [8:0] a);
    idle_in();
    br_taken = 1'b1;
    br_target = a;
    tick();
    idle_in();
  endtask
  task automatic do_call(input logic [8:0] a);
    idle_in();
    call = 1'b1;
    br_target = a;
    tick();
    idle_in();
  endtask
  task automatic do_ret();
    idle_in();
    ret = 1'b1;
    tick();
    idle_in();
  endtask
  initial begin
    start = 1'b1;
    #3;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_err", stack_err, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("start_write", pc_write, 1);
    chk("start_next", pc_next, 0);
    tick();
    start = 1'b0;
    chk("run_after_start", running, 1);
    chk("pc0", pc, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_count", pc, i);
    end
    go_abs(9'd510);
    chk("pc510", pc, 510);
    tick(); chk("wrap511", pc, 511);
    tick(); chk("wrap0", pc, 0);
    tick(); chk("wrap1", pc, 1);
    chk("wrap_err", stack_err, 0);
    go_abs(9'd20);
    br_taken = 1'b1; br_rel = 1'b1; br_target = 9'h1FC;
    #1 chk("rel_next", pc_next, 16);
    tick(); idle_in();
    chk("rel_pc", pc, 16);
    go_abs(9'd20);
    br_taken = 1'b1; br_target = 9'd42;
    tick(); idle_in();
    chk("abs_pc", pc, 42);
    go_abs(9'd10);
    call = 1'b1; br_taken = 1'b1; br_target = 9'd100;
    tick(); idle_in();
    chk("call_pc", pc, 100);
    ret = 1'b1; call = 1'b1; br_taken = 1'b1; br_target = 9'd77;
    tick(); idle_in();
    chk("ret_pc", pc, 11);
    do_call(9'd200);
    do_call(9'd300);
    do_call(9'd400);
    do_call(9'd50);
    chk("full_no_err", stack_err, 0);
    do_call(9'd60);
    chk("ovf_err", stack_err, 1);
    chk("ovf_jump", pc, 60);
    do_ret(); chk("pop401", pc, 401);
    do_ret(); chk("pop301", pc, 301);
    do_ret(); chk("pop201", pc, 201);
    do_ret(); chk("pop12", pc, 12);
    go_abs(9'd7);
    stall = 1'b1; halt_req = 1'b1; br_taken = 1'b1; br_target = 9'd99;
    #1 chk("stall_write", pc_write, 0);
    tick();
    chk("stall_pc", pc, 7);
    chk("stall_running", running, 1);
    stall = 1'b0;
    #1 chk("halt_write", pc_write, 0);
    tick(); idle_in();
    chk("halt_done", done, 1);
    chk("halt_running", running, 0);
    chk("halt_pc", pc, 7);
    tick();
    chk("halt_idle_write", pc_write, 0);
    start = 1'b1;
    #1 chk("restart_next", pc_next, 0);
    tick(); idle_in();
    chk("restart_pc", pc, 0);
    chk("restart_running", running, 1);
    chk("err_sticky_start", stack_err, 1);
    go_abs(9'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_running", running, 0);
    chk("midrst_write", pc_write, 0);
    chk("midrst_err", stack_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_pc", pc, 5);
    chk("post_rst_idle", running, 0);
    start = 1'b1;
    tick(); idle_in();
    go_abs(9'd30);
    ret = 1'b1;
    #1 chk("uf_next", pc_next, 31);
    tick(); idle_in();
    chk("uf_pc", pc, 31);
    chk("uf_err", stack_err, 1);
    go_abs(9'd5);
    do_call(9'd100);
    halt_req = 1'b1;
    tick(); idle_in();
    chk("err_in_halt", stack_err, 1);
    start = 1'b1;
    tick(); idle_in();
    chk("err_after_start", stack_err, 1);
    do_ret();
    chk("sp_cleared", pc, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
